// File: rtl/ppu_op_scheduler.sv
// Single-issue sequencer in front of the posit arithmetic core: resolves
// zero/NaR operands locally, otherwise dispatches to the core under a watchdog.
module ppu_op_scheduler #(
    parameter int N       = 16,
    parameter int OP_BITS = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_BITS-1:0] in_op,
    input  logic [N-1:0]       in_p1,
    input  logic [N-1:0]       in_p2,
    output logic               core_start,
    output logic [OP_BITS-1:0] core_op,
    output logic [N-1:0]       core_p1,
    output logic [N-1:0]       core_p2,
    output logic               core_abort,
    input  logic               core_done,
    input  logic [N-1:0]       core_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_result,
    output logic               out_special,
    output logic               out_err
);

    localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_MUL = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] OP_DIV = OP_BITS'(3);
    localparam logic [N-1:0]       NAR    = {1'b1, {(N-1){1'b0}}};
    localparam logic [CNT_W-1:0]   LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    state_t         state_next;
    logic [CNT_W-1:0] counter;
    logic           accept;
    logic           expired;
    logic           fp_hit;
    logic [N-1:0]   fp_result;
    logic           p1_zero, p2_zero, p1_nar, p2_nar;

    assign p1_zero = (in_p1 == '0);
    assign p2_zero = (in_p2 == '0);
    assign p1_nar  = (in_p1 == NAR);
    assign p2_nar  = (in_p2 == NAR);
    assign accept  = in_valid && (state == IDLE);
    assign expired = (counter == LAST);

    // Fast-path rules, checked in priority order for each opcode.
    always_comb begin
        fp_hit    = 1'b0;
        fp_result = '0;
        case (in_op)
            OP_ADD: begin
                if (p1_nar || p2_nar) begin
                    fp_hit = 1'b1; fp_result = NAR;
                end else if (p1_zero) begin
                    fp_hit = 1'b1; fp_result = in_p2;
                end else if (p2_zero) begin
                    fp_hit = 1'b1; fp_result = in_p1;
                end
            end
            OP_SUB: begin
                if (p1_nar || p2_nar) begin
                    fp_hit = 1'b1; fp_result = NAR;
                end else if (p1_zero && p2_zero) begin
                    fp_hit = 1'b1; fp_result = '0;
                end else if (p1_zero) begin
                    fp_hit = 1'b1; fp_result = (~in_p2) + N'(1);
                end else if (p2_zero) begin
                    fp_hit = 1'b1; fp_result = in_p1;
                end
            end
            OP_MUL: begin
                if (p1_nar || p2_nar) begin
                    fp_hit = 1'b1; fp_result = NAR;
                end else if (p1_zero || p2_zero) begin
                    fp_hit = 1'b1; fp_result = '0;
                end
            end
            OP_DIV: begin
                if (p1_nar || p2_nar || p2_zero) begin
                    fp_hit = 1'b1; fp_result = NAR;
                end else if (p1_zero) begin
                    fp_hit = 1'b1; fp_result = '0;
                end
            end
            default: begin
                fp_hit    = 1'b0;
                fp_result = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = fp_hit ? RESP : ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (core_done || expired) state_next = RESP;
            RESP:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A done arriving on the expiry cycle wins, so abort is gated by it.
    always_comb begin
        in_ready   = (state == IDLE);
        out_valid  = (state == RESP);
        core_start = (state == ISSUE);
        core_abort = (state == WAIT) && expired && !core_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_op     <= '0;
            core_p1     <= '0;
            core_p2     <= '0;
            out_result  <= '0;
            out_special <= 1'b0;
            out_err     <= 1'b0;
            counter     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && fp_hit) begin
                        out_result  <= fp_result;
                        out_special <= 1'b1;
                        out_err     <= 1'b0;
                    end else if (accept) begin
                        core_op <= in_op;
                        core_p1 <= in_p1;
                        core_p2 <= in_p2;
                    end
                end
                ISSUE: counter <= '0;
                WAIT: begin
                    counter <= counter + CNT_W'(1);
                    if (core_done) begin
                        out_result  <= core_result;
                        out_special <= 1'b0;
                        out_err     <= 1'b0;
                    end else if (expired) begin
                        out_result  <= NAR;
                        out_special <= 1'b0;
                        out_err     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_op_scheduler.sv
// Directed bench for ppu_op_scheduler: expected responses are queued at
// request time and popped when the scheduler presents a result.
module tb_ppu_op_scheduler;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [N-1:0]  in_p1, in_p2;
    logic          core_start;
    logic [1:0]    core_op;
    logic [N-1:0]  core_p1, core_p2;
    logic          core_abort;
    logic          core_done;
    logic [N-1:0]  core_result;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_result;
    logic          out_special;
    logic          out_err;

    typedef struct packed {
        logic [N-1:0] res;
        logic         special;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;

    ppu_op_scheduler #(.N(N), .OP_BITS(2), .TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_p1(in_p1), .in_p2(in_p2),
        .core_start(core_start), .core_op(core_op),
        .core_p1(core_p1), .core_p2(core_p2), .core_abort(core_abort),
        .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_special(out_special), .out_err(out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (core_start === 1'b1) start_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request for one cycle; optionally queues its expected result.
    task automatic applyStimulus(input logic [1:0] op, input logic [N-1:0] p1,
                                 input logic [N-1:0] p2, input logic push,
                                 input logic [N-1:0] res, input logic special,
                                 input logic err);
        exp_t e;
        in_op = op; in_p1 = p1; in_p2 = p2; in_valid = 1'b1;
        checkEq("in_ready_before_accept", in_ready, 1);
        if (push) begin
            e.res = res; e.special = special; e.err = err;
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Expects out_valid now, compares against the scoreboard head, handshakes.
    task automatic checkOutput(input string tag);
        exp_t e;
        int   waited;
        checkEq({tag, "_valid_on_time"}, out_valid, 1);
        waited = 0;
        while (out_valid !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() > 0 && out_valid === 1'b1) begin
            e = sb.pop_front();
            checkEq({tag, "_result"},  out_result,  e.res);
            checkEq({tag, "_special"}, out_special, e.special);
            checkEq({tag, "_err"},     out_err,     e.err);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkEq({tag, "_valid_dropped"}, out_valid, 0);
    endtask

    initial begin
        logic         abort_seen;
        logic [N-1:0] held;
        int           starts;

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_p1 = '0; in_p2 = '0;
        core_done = 1'b0; core_result = '0; out_ready = 1'b0;
        #12;
        checkEq("rst_in_ready",   in_ready, 1);
        checkEq("rst_out_valid",  out_valid, 0);
        checkEq("rst_core_start", core_start, 0);
        checkEq("rst_out_result", out_result, 0);
        checkEq("rst_core_p1",    core_p1, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] fast path");
        starts = start_cnt;
        applyStimulus(2'd0, 16'h0000, 16'h4000, 1'b1, 16'h4000, 1'b1, 1'b0);
        checkOutput("add_p1_zero");
        applyStimulus(2'd1, 16'h0000, 16'h4000, 1'b1, 16'hC000, 1'b1, 1'b0);
        checkOutput("sub_neg");
        applyStimulus(2'd3, 16'h4000, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0);
        checkOutput("div_by_zero");
        applyStimulus(2'd2, 16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0);
        checkOutput("mul_nar_zero");
        applyStimulus(2'd1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        checkOutput("sub_both_zero");
        checkEq("fast_no_core_start", start_cnt - starts, 0);

        $display("[TB] core path");
        applyStimulus(2'd2, 16'h4000, 16'h4800, 1'b1, 16'h4800, 1'b0, 1'b0);
        in_p1 = 16'hFFFF; in_p2 = 16'h1111;
        checkEq("mul_core_start", core_start, 1);
        checkEq("mul_core_op",    core_op, 2);
        checkEq("mul_core_p1",    core_p1, 16'h4000);
        checkEq("mul_core_p2",    core_p2, 16'h4800);
        tick();
        checkEq("mul_start_one_cycle", core_start, 0);
        tick(); tick();
        core_done = 1'b1; core_result = 16'h4800;
        tick();
        core_done = 1'b0;
        checkOutput("mul_core");
        checkEq("core_op_held", core_op, 2);

        applyStimulus(2'd0, 16'h4000, 16'h4000, 1'b1, 16'h5000, 1'b0, 1'b0);
        core_done = 1'b1; core_result = 16'h7777;
        tick();
        core_done = 1'b0;
        checkEq("issue_done_ignored", out_valid, 0);
        tick();
        core_done = 1'b1; core_result = 16'h5000;
        tick();
        core_done = 1'b0;
        checkOutput("add_core");

        $display("[TB] watchdog");
        applyStimulus(2'd0, 16'h4000, 16'h4000, 1'b1, 16'h8000, 1'b0, 1'b1);
        tick();
        abort_seen = 1'b0;
        for (int i = 0; i < 63; i++) begin
            if (core_abort === 1'b1 || out_valid === 1'b1) abort_seen = 1'b1;
            tick();
        end
        checkEq("no_early_abort", abort_seen, 0);
        checkEq("abort_at_64", core_abort, 1);
        tick();
        checkEq("abort_one_cycle", core_abort, 0);
        checkOutput("timeout");

        applyStimulus(2'd3, 16'h4000, 16'h4800, 1'b1, 16'h1234, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 63; i++) tick();
        core_done = 1'b1; core_result = 16'h1234;
        #1;
        checkEq("done_beats_abort", core_abort, 0);
        tick();
        core_done = 1'b0;
        checkOutput("late_done");

        $display("[TB] backpressure");
        applyStimulus(2'd0, 16'h0000, 16'h3000, 1'b1, 16'h3000, 1'b1, 1'b0);
        in_op = 2'd2; in_p1 = 16'h5000; in_p2 = 16'h0000; in_valid = 1'b1;
        held = out_result;
        abort_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0)
                abort_seen = 1'b1;
            tick();
        end
        checkEq("backpressure_hold", abort_seen, 0);
        checkOutput("held_result");
        checkEq("reaccept_ready", in_ready, 1);
        sb.push_back('{res: 16'h0000, special: 1'b1, err: 1'b0});
        tick();
        in_valid = 1'b0;
        checkOutput("reaccepted");

        $display("[TB] reset mid-flight");
        applyStimulus(2'd2, 16'h4000, 16'h4800, 1'b0, 16'h0, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        checkEq("midrst_in_ready",  in_ready, 1);
        checkEq("midrst_core_op",   core_op, 0);
        checkEq("midrst_core_p1",   core_p1, 0);
        checkEq("midrst_abort",     core_abort, 0);
        checkEq("midrst_out_valid", out_valid, 0);
        tick();
        rst_n = 1'b1;
        core_done = 1'b1; core_result = 16'hABCD;
        tick();
        core_done = 1'b0;
        tick();
        checkEq("late_done_ignored", out_valid, 0);
        checkEq("post_rst_ready",    in_ready, 1);
        checkEq("scoreboard_empty",  sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
